// File: rtl/conv_window_reader_if.sv
// rtl/conv_window_reader_if.sv - read-side handshake bundle for the conv window reader
interface conv_window_reader_if #(
    parameter int ADDR_W = 10
);
    logic              validToRead;
    logic              macReady;
    logic [ADDR_W-1:0] rAddr;
    logic              rdEn;
    logic              tapValid;
    logic [3:0]        tapIdx;
    logic              winLast;
    logic              imgLast;
    logic              bankDone;

    modport master (
        input  validToRead, macReady,
        output rAddr, rdEn, tapValid, tapIdx, winLast, imgLast, bankDone
    );

    modport slave (
        output validToRead, macReady,
        input  rAddr, rdEn, tapValid, tapIdx, winLast, imgLast, bankDone
    );
endinterface

// File: rtl/conv_window_reader.sv
// rtl/conv_window_reader.sv - stride-2 3x3 window address generator over a ping-pong 9x9 image RAM
module conv_window_reader #(
    parameter int IMG_W   = 9,
    parameter int K       = 3,
    parameter int STRIDE  = 2,
    parameter int BANK_SZ = 81,
    parameter int ADDR_W  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    conv_window_reader_if.master bus
);
    localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
    localparam int KW    = (K > 1) ? $clog2(K) : 1;
    localparam int OW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE
    } state_t;

    state_t            state;
    logic              bank;
    logic [KW-1:0]     kx;
    logic [KW-1:0]     ky;
    logic [OW-1:0]     ox;
    logic [OW-1:0]     oy;
    logic              tap_valid;
    logic [3:0]        tap_idx;
    logic              win_last;
    logic              img_last;
    logic              bank_done;
    logic [ADDR_W-1:0] addr;
    logic              issue;
    logic              last_tap;
    logic              last_win;

    // A read issues only while walking an image and the MAC can take the tap
    assign issue    = (state == READ) && bus.macReady;
    assign last_tap = (kx == KW'(K - 1)) && (ky == KW'(K - 1));
    assign last_win = (ox == OW'(OUT_W - 1)) && (oy == OW'(OUT_W - 1));

    // Address follows the counters directly, so it parks at the bank base whenever they are clear
    always_comb begin
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        base = bank ? ADDR_W'(BANK_SZ) : '0;
        row  = ADDR_W'(oy) * ADDR_W'(STRIDE) + ADDR_W'(ky);
        col  = ADDR_W'(ox) * ADDR_W'(STRIDE) + ADDR_W'(kx);
        addr = base + row * ADDR_W'(IMG_W) + col;
    end

    // Sequencer: counters, bank select and the one-cycle-delayed tap tags
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bank      <= 1'b0;
            kx        <= '0;
            ky        <= '0;
            ox        <= '0;
            oy        <= '0;
            tap_valid <= 1'b0;
            tap_idx   <= '0;
            win_last  <= 1'b0;
            img_last  <= 1'b0;
            bank_done <= 1'b0;
        end else begin
            tap_valid <= issue;
            tap_idx   <= 4'(ky) * 4'(K) + 4'(kx);
            win_last  <= issue && last_tap;
            img_last  <= issue && last_tap && last_win;
            bank_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.validToRead) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        if (kx == KW'(K - 1)) begin
                            kx <= '0;
                            if (ky == KW'(K - 1)) begin
                                ky <= '0;
                                if (ox == OW'(OUT_W - 1)) begin
                                    ox <= '0;
                                    if (oy == OW'(OUT_W - 1)) begin
                                        oy <= '0;
                                    end else begin
                                        oy <= oy + 1'b1;
                                    end
                                end else begin
                                    ox <= ox + 1'b1;
                                end
                            end else begin
                                ky <= ky + 1'b1;
                            end
                        end else begin
                            kx <= kx + 1'b1;
                        end
                        if (last_tap && last_win) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    bank_done <= 1'b1;
                    bank      <= ~bank;
                    kx        <= '0;
                    ky        <= '0;
                    ox        <= '0;
                    oy        <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rAddr    = addr;
    assign bus.rdEn     = issue;
    assign bus.tapValid = tap_valid;
    assign bus.tapIdx   = tap_idx;
    assign bus.winLast  = win_last;
    assign bus.imgLast  = img_last;
    assign bus.bankDone = bank_done;
endmodule

// File: tb/tb_conv_window_reader.sv
// tb/tb_conv_window_reader.sv - directed bench for conv_window_reader
module tb_conv_window_reader;
    logic clk;
    logic reset;
    int   total;
    int   passed;
    int   exp_addr[432];

    conv_window_reader_if #(.ADDR_W(10)) bus ();

    conv_window_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic valid;
        logic mac;
        logic rd;
        int   addr;
        logic tv;
        int   idx;
        logic wl;
        logic il;
        logic bd;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.validToRead = 1'b0;
        bus.macReady = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run(input int n_reads, input int extra);
        int   n = 0;
        int   post = 0;
        int   cyc = 0;
        logic prev_rd = 1'b0;
        int   prev_idx = 0;
        logic prev_wl = 1'b0;
        logic prev_il = 1'b0;
        logic il_prev = 1'b0;
        bus.validToRead = 1'b1;
        bus.macReady = 1'b1;
        while (1) begin
            #1;
            check("tap_valid", int'(bus.tapValid), int'(prev_rd));
            if (prev_rd) begin
                check("tap_idx", int'(bus.tapIdx), prev_idx);
                check("win_last", int'(bus.winLast), int'(prev_wl));
                check("img_last", int'(bus.imgLast), int'(prev_il));
            end
            check("bank_done", int'(bus.bankDone), int'(il_prev));
            if (il_prev) check("park_addr", int'(bus.rAddr), ((n / 144) % 2) * 81);
            il_prev = prev_rd && prev_il;
            prev_rd = bus.rdEn;
            if (bus.rdEn) begin
                if (n < 432) check("r_addr", int'(bus.rAddr), exp_addr[n]);
                prev_idx = n % 9;
                prev_wl  = (n % 9) == 8;
                prev_il  = (n % 144) == 143;
                n++;
            end
            if (n >= n_reads) begin
                if (post == extra) break;
                post++;
            end
            cyc++;
            if (cyc > 2000) begin
                check("read_budget", n, n_reads);
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        bus.validToRead = 1'b0;
        bus.macReady = 1'b0;

        for (int img = 0; img < 3; img++)
            for (int oy = 0; oy < 4; oy++)
                for (int ox = 0; ox < 4; ox++)
                    for (int ky = 0; ky < 3; ky++)
                        for (int kx = 0; kx < 3; kx++)
                            exp_addr[img*144 + ((oy*4 + ox)*3 + ky)*3 + kx] =
                                (img % 2) * 81 + (oy*2 + ky) * 9 + ox*2 + kx;

        //             valid mac  rd  addr tv  idx wl  il  bd
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 0,  1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 0,  1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1,  1'b1, 0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 2,  1'b1, 1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 9,  1'b1, 2, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 10, 1'b1, 3, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 11, 1'b1, 4, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 11, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 11, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 11, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 18, 1'b1, 5, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 19, 1'b1, 6, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 20, 1'b1, 7, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 2,  1'b1, 8, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 3,  1'b1, 0, 1'b0, 1'b0, 1'b0};

        // first window with a macReady stall after address 10
        do_reset();
        for (int i = 0; i < 15; i++) begin
            bus.validToRead = vecs[i].valid;
            bus.macReady = vecs[i].mac;
            #1;
            check($sformatf("v%0d_rd_en", i), int'(bus.rdEn), int'(vecs[i].rd));
            check($sformatf("v%0d_r_addr", i), int'(bus.rAddr), vecs[i].addr);
            check($sformatf("v%0d_tap_valid", i), int'(bus.tapValid), int'(vecs[i].tv));
            if (vecs[i].tv || i == 0)
                check($sformatf("v%0d_tap_idx", i), int'(bus.tapIdx), vecs[i].idx);
            check($sformatf("v%0d_win_last", i), int'(bus.winLast), int'(vecs[i].wl));
            check($sformatf("v%0d_img_last", i), int'(bus.imgLast), int'(vecs[i].il));
            check($sformatf("v%0d_bank_done", i), int'(bus.bankDone), int'(vecs[i].bd));
            @(negedge clk);
        end

        // validToRead held low: reader must sit idle at address 0
        do_reset();
        bus.macReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (i % 5 == 4) begin
                check("idle_rd_en", int'(bus.rdEn), 0);
                check("idle_r_addr", int'(bus.rAddr), 0);
            end
            @(negedge clk);
        end

        // three back-to-back images: bank 0, bank 1, wrap to bank 0
        run(432, 3);
        @(negedge clk);

        // reset at read 70 of bank 1 aborts the image
        do_reset();
        run(144 + 70, 0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rst_rd_en", int'(bus.rdEn), 0);
        check("rst_r_addr", int'(bus.rAddr), 0);
        check("rst_tap_valid", int'(bus.tapValid), 0);
        check("rst_win_last", int'(bus.winLast), 0);
        check("rst_img_last", int'(bus.imgLast), 0);
        check("rst_bank_done", int'(bus.bankDone), 0);
        reset = 1'b0;
        @(negedge clk);
        run(9, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
